// File: rtl/boot_pkg.sv
// boot_pkg: shared parameters, state encoding and length clamp for the boot loader
package boot_pkg;
    localparam int DEPTH          = 32;
    localparam int ADDR_W         = 5;
    localparam int CNT_W          = ADDR_W + 1;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {IDLE, RECV, WRITE, VRD, VCMP, CHECK, DONE} state_t;

    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        return (len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : len;
    endfunction
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte stream and memory bus between loader, byte source and memory
interface boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] realaddr;
    logic [31:0] dout;
    logic [31:0] din;
    logic        W;

    modport master (input rx_data, rx_valid, din, output rx_ready, realaddr, dout, W);
    modport slave  (output rx_data, rx_valid, din, input rx_ready, realaddr, dout, W);
endinterface

// File: rtl/boot_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from accepted bytes
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  rx_data,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0] cnt;

    assign word_valid = take && (cnt == 2'(BYTES_PER_WORD - 1));

    // byte k of a word lands in bits [8k+7:8k]; count restarts on each new image
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt  <= '0;
            word <= '0;
        end else if (take) begin
            cnt             <= cnt + 2'd1;
            word[8*cnt +: 8] <= rx_data;
        end
    end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a byte-stream image into memory, reads it back and verifies a checksum
module boot_loader
    import boot_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] nwords,
    boot_loader_if.master    bus,
    output logic             proc_hold,
    output logic             done,
    output logic             pass,
    output logic             run
);
    state_t            state, nxt;
    logic [CNT_W-1:0]  n, waddr, raddr;
    logic [31:0]       wsum, vsum, word;
    logic              go, take, word_valid;

    assign go        = start && (state == IDLE || state == DONE);
    assign take      = bus.rx_valid && bus.rx_ready;
    assign proc_hold = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign run       = done && pass;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr        (go),
        .take       (take),
        .rx_data    (bus.rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // next state and bus outputs; the bus is idle (all zero) unless loading or verifying
    always_comb begin
        nxt          = state;
        bus.rx_ready = 1'b0;
        bus.W        = 1'b0;
        bus.realaddr = '0;
        bus.dout     = '0;
        case (state)
            IDLE, DONE: if (go) nxt = (clamp_len(nwords) == '0) ? DONE : RECV;
            RECV: begin
                bus.rx_ready = 1'b1;
                if (word_valid) nxt = WRITE;
            end
            WRITE: begin
                bus.W        = 1'b1;
                bus.realaddr = 32'(waddr[ADDR_W-1:0]);
                bus.dout     = word;
                nxt          = (waddr == n - 1'b1) ? VRD : RECV;
            end
            VRD: begin
                bus.realaddr = 32'(raddr[ADDR_W-1:0]);
                nxt          = VCMP;
            end
            VCMP: begin
                bus.realaddr = 32'(raddr[ADDR_W-1:0]);
                nxt          = (raddr == n - 1'b1) ? CHECK : VRD;
            end
            CHECK:   nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    // length, addresses, checksums and verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            n     <= '0;
            waddr <= '0;
            raddr <= '0;
            wsum  <= '0;
            vsum  <= '0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (go) begin
                    n     <= clamp_len(nwords);
                    waddr <= '0;
                    raddr <= '0;
                    wsum  <= '0;
                    vsum  <= '0;
                    pass  <= (clamp_len(nwords) == '0);
                end
                WRITE: begin
                    wsum  <= wsum + word;
                    waddr <= waddr + 1'b1;
                end
                VCMP: begin
                    vsum  <= vsum + bus.din;
                    raddr <= raddr + 1'b1;
                end
                CHECK:   pass <= (vsum == wsum);
                default: ;
            endcase
        end
    end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Bus initiator that preloads the 32-word memory over the same W/realaddr/dout/din interface that core0 uses.
- Assembles little-endian 32-bit words from a byte stream and writes them to consecutive addresses from 0.
- Reads the whole image back and compares a checksum of the readback against a checksum of what it wrote.
- Holds the processor in reset while busy; asserts run only when the image passes the check.
- A top-level mux selects loader or core0 as memory master using proc_hold.

Parameters:
- DEPTH, 32, number of memory words (maximum image length).
- ADDR_W, 5, memory address bits; realaddr[ADDR_W-1:0] reaches memory.
- CNT_W, 6, width of nwords and word counters (ADDR_W+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; sampled only in IDLE and DONE.
- nwords  input  CNT_W  image length in words; sampled on start.
- rx_data  input  8  incoming image byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- realaddr  output  32  memory word address; upper bits are 0.
- dout  output  32  write data to memory.
- W  output  1  memory write enable.
- din  input  32  memory read data; valid the cycle after realaddr is presented.
- proc_hold  output  1  high while busy; keeps core0 in reset and selects loader as memory master.
- done  output  1  load and verify complete; sticky.
- pass  output  1  checksum matched; valid while done=1.
- run  output  1  done and pass; drives core0 run.

Behaviour:
- Interface decisions: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; all counters and checksums 0.
- Byte transfer occurs on a rising edge with rx_valid=1 and rx_ready=1.
- rx_ready=1 only in RECV.
- Byte k (0..3) of a word goes to word[8k+7:8k], little-endian.
- States:
  - IDLE: on start, latch n = min(nwords, DEPTH) and clear wsum, vsum, waddr, raddr and byte count. If n=0, go to DONE with pass=1. Otherwise go to RECV.
  - RECV: accept bytes. After the 4th byte, go to WRITE on the next cycle. Stalls (rx_valid=0) of any length are allowed.
  - WRITE: one cycle. W=1, realaddr=waddr, dout=word. Register update: wsum += word (mod 2^32), waddr++. If waddr == n-1, go to VRD; else go to RECV.
  - VRD: W=0, realaddr=raddr; go to VCMP.
  - VCMP: vsum += din; raddr++. If raddr == n-1, go to CHECK; else go to VRD.
  - CHECK: pass <= (vsum == wsum); go to DONE.
  - DONE: done=1; run=pass; proc_hold=0; realaddr, dout and W are 0. Stay until start (restarts as from IDLE) or reset.
- proc_hold=1 in RECV, WRITE, VRD, VCMP and CHECK.
- done and pass drop to 0 in the cycle after a restart is accepted.
- Latency for n words with no stalls: 4n byte cycles + n write cycles + 2n verify cycles + 1 check cycle, then done.
- start while busy is ignored; nwords is not re-sampled.
- reset mid-operation returns to IDLE immediately. The partial image is left in memory; run stays 0.
- W is never high outside WRITE. W is high for exactly 1 cycle per word.
- Addresses never exceed n-1 and never wrap.

Decomposition:
- Shared package boot_pkg:
  - state encoding enum (IDLE, RECV, WRITE, VRD, VCMP, CHECK, DONE);
  - DEPTH, ADDR_W, CNT_W;
  - BYTES_PER_WORD = 4.
- One natural sub-module, byte_packer: byte-to-word assembler with a 2-bit byte count and word_valid pulse.
- FSM, counters and checksums stay in boot_loader.

Test Plan:
- nwords=1, bytes 78 56 34 12 back to back -> one W pulse at realaddr 0 with dout=0x12345678. One read of address 0, then done=1, pass=1, run=1 after 4+1+2+1 = 8 cycles past the first byte.
- nwords=3 with random rx_valid gaps -> W pulses at addresses 0,1,2 only. Verify reads 0,1,2. pass=1. rx_ready is 0 outside RECV.
- nwords=0 -> DONE on the cycle after start, pass=1, W never asserted, rx_ready stays 0.
- nwords=2; the bench memory flips bit 0 of word 1 on readback -> done=1, pass=0, run=0, proc_hold=0.
- reset asserted after 6 bytes of nwords=4 -> next cycle all outputs are 0, state is IDLE. A subsequent start with nwords=1 completes with pass=1.
- nwords=40 -> clamped to 32: exactly 32 writes at addresses 0..31, then verify. A start pulse during RECV is ignored (word count unchanged).
